fpu_addsub_sched: RTL and testbench
===================================

Name: fpu_addsub_sched

Overview:
Shares one FPU add/sub datapath and its registered exception checker between two requesters. Per operation it:
- arbitrates between the requesters round-robin and latches the operands;
- drives the operands to the exception checker and waits one cycle for the registered flag;
- resolves special cases locally, or launches the normal datapath and waits for it;
- returns the result to the originating requester.
One operation is in flight at a time. The block sits between the issue logic and the addsub/exception pair.

Parameters:
WIDTH, 32, total float width
EXP_BITS, 8, exponent width
MANT_BITS, 23, fraction width
TIMEOUT, 64, max cycles in RUN before abort (>=2)

Ports:
clk  in  1  clock, single domain
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 request valid
req0_ready  out  1  requester 0 accept
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req0_op  in  1  0=add, 1=sub
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0
opnd_a  out  WIDTH  latched A, to exception checker and datapath
opnd_b  out  WIDTH  latched B
opnd_op  out  1  latched op
exc_flag  in  3  registered flag from checker
exc_copied  in  WIDTH-1  registered copied operand (exp,frac)
dp_start  out  1  one-cycle datapath launch pulse
dp_done  in  1  datapath result valid, one-cycle pulse
dp_result  in  WIDTH  datapath result
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_result  out  WIDTH  final result
rsp_id  out  1  originating requester
rsp_flag  out  3  exc_flag captured in DECIDE
rsp_err  out  1  datapath timeout

Behaviour:
- Reset: sync. Forces state IDLE. All outputs 0 at reset: opnd_*, rsp_*, dp_start, req*_ready, rsp_err. Round-robin pointer last_grant=1, so requester 0 wins first. Watchdog cleared.
- Reset mid-operation: the in-flight op is discarded with no response. A dp_done arriving later is ignored, because IDLE ignores dp_done.
- FSM IDLE -> CHECK -> DECIDE -> {RUN ->} RESP -> IDLE.
- IDLE:
  - grant = round-robin among valid requesters; when only one is valid, it wins.
  - reqN_ready = (state==IDLE) && grant==N. It is combinational and may depend on valid.
  - On handshake, latch a/b/op/id, update last_grant, go to CHECK.
- CHECK: operands are stable on opnd_*; the checker samples them at the end of this cycle.
- DECIDE:
  - exc_flag is valid; capture it into rsp_flag.
  - If flag==000: pulse dp_start this cycle, clear the watchdog, go to RUN.
  - Else: load rsp_result via the resolve map, go to RESP.
- Resolve map (sa/sb = sign of latched A/B, QNAN = {0, all-ones exp, 1, zeros}):
  - 001: QNAN
  - 010: latched A verbatim
  - 011: latched B verbatim
  - 100: {~sb, all-ones exp, 0 frac}
  - 101: zero with sign = sa&sb for add, sa&~sb for sub
  - 110: {~sb, exc_copied}
  - 111: +0
- RUN:
  - The watchdog increments each cycle.
  - On dp_done: capture dp_result, go to RESP. dp_done wins over a same-cycle expiry.
  - When the watchdog reaches TIMEOUT-1 without dp_done: rsp_result=QNAN, rsp_err=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_result/id/flag/err are held stable while rsp_ready=0.
  - On rsp_ready, go to IDLE, deassert rsp_valid, clear rsp_err.
- Latency (exception path): rsp_valid rises 3 cycles after the request handshake cycle. The next request can be accepted in the cycle after the response handshake.
- Latency (normal path): 3 cycles + datapath latency.
- dp_done outside RUN is ignored.
- A requester holding valid while the other is granted must keep its payload stable (valid/ready rule).

Decomposition:
- Shared package fpu_pkg:
  - FLAG_* 3-bit codes: NONE, NAN, COPY_A, COPY_B, FIN_MIN_INF, ZERO_MIN_ZERO, ZERO_MIN_SOME, SUB_SAME_VAL
  - QNAN constant
  - FSM state encoding
- Sub-module fpu_exc_resolve: combinational; inputs flag, latched A/B, op, exc_copied; output result word. It is reused by the multiplier scheduler later.

Test Plan:
1. Basic add:
   - Stimulus: req0 a=0x3F800000 b=0x40000000 op=0; exc_flag=000; dp_done 4 cycles after dp_start with 0x40400000.
   - Response: exactly one dp_start pulse; rsp_result=0x40400000, id=0, flag=000, err=0.
2. Arbitration:
   - Stimulus: after reset, req0 and req1 valid in the same cycle, held.
   - Response: req0 granted first, req1 second; rsp_id sequence 0,1. Repeat with both valid: order alternates.
3. NaN bypass:
   - Stimulus: exc_flag=001.
   - Response: no dp_start; rsp_result=0x7FC00000; rsp_valid exactly 3 cycles after handshake.
4. Zero minus B:
   - Stimulus: a=0x00000000 b=0x40000000 op=1; flag=110, exc_copied=0x40000000.
   - Response: rsp_result=0xC0000000.
5. Zero plus/minus zero:
   - Stimulus: flag=101, a=0x80000000 b=0x80000000.
   - Response: op=0 gives 0x80000000; op=1 gives 0x00000000.
6. Timeout and reset:
   - Stimulus: dp_done withheld.
   - Response: after TIMEOUT cycles, rsp_err=1 and rsp_result=0x7FC00000, held under rsp_ready=0 for 5 cycles.
   - Stimulus: rst asserted in RUN, late dp_done afterwards.
   - Response: no rsp_valid produced.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU schedulers.
//   FLAG_*  : 3-bit exception-checker codes
//   QNAN    : canonical quiet NaN for the default 32-bit format
//   state_t : add/sub scheduler FSM encoding
package fpu_pkg;

    localparam logic [2:0] FLAG_NONE          = 3'b000;
    localparam logic [2:0] FLAG_NAN           = 3'b001;
    localparam logic [2:0] FLAG_COPY_A        = 3'b010;
    localparam logic [2:0] FLAG_COPY_B        = 3'b011;
    localparam logic [2:0] FLAG_FIN_MIN_INF   = 3'b100;
    localparam logic [2:0] FLAG_ZERO_MIN_ZERO = 3'b101;
    localparam logic [2:0] FLAG_ZERO_MIN_SOME = 3'b110;
    localparam logic [2:0] FLAG_SUB_SAME_VAL  = 3'b111;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DECIDE,
        ST_RUN,
        ST_RESP
    } state_t;

endpackage

// File: rtl/fpu_exc_resolve.sv
// Combinational special-case resolver: maps a checker flag plus the latched
// operands to the final result word, bypassing the arithmetic datapath.
//   flag_i   : exception flag from the checker
//   a_i/b_i  : latched operands
//   op_i     : 0=add, 1=sub
//   copied_i : checker's copied operand (exponent + fraction)
//   result_o : resolved result
module fpu_exc_resolve
    import fpu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
) (
    input  logic [2:0]       flag_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    input  logic [WIDTH-2:0] copied_i,
    output logic [WIDTH-1:0] result_o
);
    localparam logic [WIDTH-1:0] QNAN_W =
        {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

    logic sa, sb;
    assign sa = a_i[WIDTH-1];
    assign sb = b_i[WIDTH-1];

    always_comb begin
        result_o = '0;
        case (flag_i)
            FLAG_NAN:           result_o = QNAN_W;
            FLAG_COPY_A:        result_o = a_i;
            FLAG_COPY_B:        result_o = b_i;
            FLAG_FIN_MIN_INF:   result_o = {~sb, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
            // Signed zero: -0 only when both effective signs are negative.
            FLAG_ZERO_MIN_ZERO: result_o = {(op_i ? (sa & ~sb) : (sa & sb)), {(WIDTH-1){1'b0}}};
            FLAG_ZERO_MIN_SOME: result_o = {~sb, copied_i};
            FLAG_SUB_SAME_VAL:  result_o = '0;
            default:            result_o = '0;
        endcase
    end

endmodule

// File: rtl/fpu_addsub_sched.sv
// Two-requester scheduler for a shared FPU add/sub datapath and its
// registered exception checker. One operation in flight at a time.
//   req0_*/req1_* : requester valid/ready handshakes with operands and op
//   opnd_*        : latched operands to checker and datapath
//   exc_flag/exc_copied : registered checker outputs (valid in DECIDE)
//   dp_start/dp_done/dp_result : datapath launch and completion
//   rsp_*         : response to the originating requester
module fpu_addsub_sched
    import fpu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic [WIDTH-1:0] opnd_a,
    output logic [WIDTH-1:0] opnd_b,
    output logic             opnd_op,
    input  logic [2:0]       exc_flag,
    input  logic [WIDTH-2:0] exc_copied,
    output logic             dp_start,
    input  logic             dp_done,
    input  logic [WIDTH-1:0] dp_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_id,
    output logic [2:0]       rsp_flag,
    output logic             rsp_err
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] QNAN_W =
        {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             op_q, op_d, id_q, id_d, lg_q, lg_d, err_q, err_d;
    logic [2:0]       flag_q, flag_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             grant, idle, hs;
    logic [WIDTH-1:0] resolved;

    fpu_exc_resolve #(
        .WIDTH(WIDTH), .EXP_BITS(EXP_BITS), .MANT_BITS(MANT_BITS)
    ) u_resolve (
        .flag_i   (exc_flag),
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .copied_i (exc_copied),
        .result_o (resolved)
    );

    // Round-robin: on contention the requester not granted last time wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ~lg_q;
        else if (req1_valid)          grant = 1'b1;
    end

    assign idle       = (state_q == ST_IDLE);
    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;
    assign hs         = req0_ready || req1_ready;

    assign opnd_a     = a_q;
    assign opnd_b     = b_q;
    assign opnd_op    = op_q;
    assign dp_start   = (state_q == ST_DECIDE) && (exc_flag == FLAG_NONE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = res_q;
    assign rsp_id     = id_q;
    assign rsp_flag   = flag_q;
    assign rsp_err    = err_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        lg_d    = lg_q;
        flag_d  = flag_q;
        res_d   = res_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    a_d     = grant ? req1_a  : req0_a;
                    b_d     = grant ? req1_b  : req0_b;
                    op_d    = grant ? req1_op : req0_op;
                    id_d    = grant;
                    lg_d    = grant;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK:  state_d = ST_DECIDE;
            ST_DECIDE: begin
                flag_d = exc_flag;
                if (exc_flag == FLAG_NONE) begin
                    wd_d    = '0;
                    state_d = ST_RUN;
                end else begin
                    res_d   = resolved;
                    state_d = ST_RESP;
                end
            end
            ST_RUN: begin
                // Completion takes priority over a same-cycle watchdog expiry.
                if (dp_done) begin
                    res_d   = dp_result;
                    state_d = ST_RESP;
                end else if (wd_q == WD_MAX) begin
                    res_d   = QNAN_W;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            id_q    <= 1'b0;
            lg_q    <= 1'b1;
            flag_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            lg_q    <= lg_d;
            flag_q  <= flag_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_fpu_addsub_sched.sv
module tb_fpu_addsub_sched;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0, req0_op = 0, req1_op = 0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [31:0] opnd_a, opnd_b;
    logic        opnd_op;
    logic [2:0]  exc_flag = 0;
    logic [30:0] exc_copied = 0;
    logic        dp_start;
    logic        dp_done = 0;
    logic [31:0] dp_result = 0;
    logic        rsp_valid, rsp_ready = 0, rsp_id, rsp_err;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flag;

    int vectors = 0, miscompares = 0;

    // Datapath model: responds dp_dly cycles after dp_start when enabled.
    bit dp_en  = 1;
    int dp_dly = 4;
    int dp_cnt = 0;
    int starts = 0;

    always #5 clk = ~clk;

    fpu_addsub_sched #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .opnd_op(opnd_op),
        .exc_flag(exc_flag), .exc_copied(exc_copied),
        .dp_start(dp_start), .dp_done(dp_done), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_id(rsp_id), .rsp_flag(rsp_flag), .rsp_err(rsp_err)
    );

    always @(negedge clk) begin
        dp_done <= 1'b0;
        if (dp_start) begin
            starts <= starts + 1;
            if (dp_en) dp_cnt <= dp_dly;
        end else if (dp_cnt > 0) begin
            dp_cnt <= dp_cnt - 1;
            if (dp_cnt == 1) dp_done <= 1'b1;
        end
    end

    // Resolve-path vectors: flag, a, b, op, copied, expected result.
    logic [2:0]  tv_f [10] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b100,
                               3'b111, 3'b110, 3'b101, 3'b101, 3'b101};
    logic [31:0] tv_a [10] = '{32'h3F800000, 32'hC0A00000, 32'hC0A00000, 32'h3F800000, 32'h3F800000,
                               32'h40000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000};
    logic [31:0] tv_b [10] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'hC0000000,
                               32'h40000000, 32'h40000000, 32'h80000000, 32'h80000000, 32'h00000000};
    logic        tv_o [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [30:0] tv_c [10] = '{31'h0, 31'h0, 31'h0, 31'h0, 31'h0, 31'h0, 31'h40000000, 31'h0, 31'h0, 31'h0};
    logic [31:0] tv_r [10] = '{32'h7FC00000, 32'hC0A00000, 32'h3F800000, 32'hFF800000, 32'h7F800000,
                               32'h00000000, 32'hC0000000, 32'h80000000, 32'h00000000, 32'h80000000};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready = 0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Offers one request and returns just after the handshake edge.
    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic op, output bit ok);
        ok = 0;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin ok = 1; break; end
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic get_rsp(input int budget, output logic [31:0] res, output logic id,
                           output logic [2:0] fl, output logic er, output int lat, output bit ok);
        lat = 0;
        ok  = 0;
        res = 'x; id = 'x; fl = 'x; er = 'x;
        while (lat < budget) begin
            if (rsp_valid) begin ok = 1; break; end
            tick;
            lat++;
        end
        if (ok) begin res = rsp_result; id = rsp_id; fl = rsp_flag; er = rsp_err; end
    endtask

    task automatic ack;
        rsp_ready = 1;
        tick;
        rsp_ready = 0;
    endtask

    task automatic test_reset;
        do_reset;
        vectors++;
        if ({req0_ready, req1_ready, rsp_valid, dp_start, rsp_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 00000", {req0_ready, req1_ready, rsp_valid, dp_start, rsp_err});
        end
        vectors++;
        if ({rsp_result, rsp_id, rsp_flag} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_rsp got %h want 0", {rsp_result, rsp_id, rsp_flag});
        end
        vectors++;
        if ({opnd_a, opnd_b, opnd_op} !== 65'h0) begin
            miscompares++;
            $display("FAIL reset_opnd got %h want 0", {opnd_a, opnd_b, opnd_op});
        end
    endtask

    task automatic test_basic_add;
        logic [31:0] r; logic id, er; logic [2:0] fl; int lat, s0; bit ok;
        exc_flag = 3'b000; dp_en = 1; dp_dly = 4; dp_result = 32'h40400000;
        #1; s0 = starts;
        issue(0, 32'h3F800000, 32'h40000000, 1'b0, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL add_handshake got 0 want 1"); end
        vectors++;
        if (opnd_a !== 32'h3F800000 || opnd_b !== 32'h40000000 || opnd_op !== 1'b0) begin
            miscompares++;
            $display("FAIL add_opnd got %h %h %b want 3f800000 40000000 0", opnd_a, opnd_b, opnd_op);
        end
        get_rsp(50, r, id, fl, er, lat, ok);
        vectors++;
        if (!ok || r !== 32'h40400000 || id !== 1'b0 || fl !== 3'b000 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL add_rsp got ok=%0d %h id=%b fl=%b err=%b want 40400000 id=0 fl=000 err=0", ok, r, id, fl, er);
        end
        vectors++;
        if (starts - s0 !== 1) begin
            miscompares++;
            $display("FAIL add_dp_start got %0d pulses want 1", starts - s0);
        end
        ack;
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_release got %b want 0", rsp_valid); end
    endtask

    task automatic run_pair(input bit first);
        logic [31:0] r; logic id, er; logic [2:0] fl; int lat; bit ok; bit exp;
        exc_flag = 3'b001;
        req0_valid = 1; req0_a = 32'h11111111; req0_b = 32'h22222222; req0_op = 0;
        req1_valid = 1; req1_a = 32'h33333333; req1_b = 32'h44444444; req1_op = 1;
        for (int k = 0; k < 2; k++) begin
            exp = (k == 0) ? first : ~first;
            #1;
            vectors++;
            if ({req1_ready, req0_ready} !== (exp ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL arb_grant got r1r0=%b%b want winner %0d", req1_ready, req0_ready, exp);
            end
            @(posedge clk);
            #1;
            if (exp) req1_valid = 0; else req0_valid = 0;
            get_rsp(20, r, id, fl, er, lat, ok);
            vectors++;
            if (!ok || id !== exp || r !== 32'h7FC00000) begin
                miscompares++;
                $display("FAIL arb_rsp got ok=%0d id=%b %h want id=%0d 7fc00000", ok, id, r, exp);
            end
            ack;
        end
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic test_arbitration;
        logic [31:0] r; logic id, er; logic [2:0] fl; int lat; bit ok;
        do_reset;
        run_pair(1'b0);
        run_pair(1'b0);
        issue(0, 32'h0, 32'h0, 1'b0, ok);
        get_rsp(20, r, id, fl, er, lat, ok);
        ack;
        run_pair(1'b1);
    endtask

    task automatic test_resolve;
        logic [31:0] r; logic id, er; logic [2:0] fl; int lat, s0; bit ok;
        for (int i = 0; i < 10; i++) begin
            exc_flag = tv_f[i];
            exc_copied = tv_c[i];
            #1; s0 = starts;
            issue(i[0], tv_a[i], tv_b[i], tv_o[i], ok);
            get_rsp(20, r, id, fl, er, lat, ok);
            vectors++;
            if (!ok || r !== tv_r[i] || fl !== tv_f[i] || id !== i[0] || er !== 1'b0) begin
                miscompares++;
                $display("FAIL resolve[%0d] got %h fl=%b id=%b err=%b want %h fl=%b id=%0d err=0",
                         i, r, fl, id, er, tv_r[i], tv_f[i], i[0]);
            end
            vectors++;
            if (lat !== 2 || starts != s0) begin
                miscompares++;
                $display("FAIL resolve_lat[%0d] got lat=%0d starts=%0d want lat=2 starts=0", i, lat, starts - s0);
            end
            ack;
        end
        exc_copied = 0;
    endtask

    task automatic test_timeout;
        logic [31:0] r; logic id, er; logic [2:0] fl; int lat; bit ok, stable;
        exc_flag = 3'b000;
        dp_en = 0;
        issue(1, 32'h3F800000, 32'h3F800000, 1'b0, ok);
        get_rsp(200, r, id, fl, er, lat, ok);
        vectors++;
        if (!ok || er !== 1'b1 || r !== 32'h7FC00000 || id !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_rsp got ok=%0d err=%b %h id=%b want err=1 7fc00000 id=1", ok, er, r, id);
        end
        vectors++;
        if (lat !== TIMEOUT + 2) begin
            miscompares++;
            $display("FAIL timeout_lat got %0d want %0d", lat, TIMEOUT + 2);
        end
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 32'h7FC00000 || rsp_id !== 1'b1)
                stable = 0;
        end
        vectors++;
        if (!stable) begin miscompares++; $display("FAIL timeout_hold got unstable want held"); end
        ack;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear got valid=%b err=%b want 0 0", rsp_valid, rsp_err);
        end
        dp_en = 1;
        // Completion landing in the last watchdog cycle must win.
        dp_dly = TIMEOUT;
        dp_result = 32'h12345678;
        issue(0, 32'h3F800000, 32'h3F800000, 1'b0, ok);
        get_rsp(200, r, id, fl, er, lat, ok);
        vectors++;
        if (!ok || er !== 1'b0 || r !== 32'h12345678) begin
            miscompares++;
            $display("FAIL done_vs_expiry got ok=%0d err=%b %h want err=0 12345678", ok, er, r);
        end
        ack;
        dp_dly = 4;
    endtask

    task automatic test_reset_in_run;
        logic [31:0] r; logic id, er; logic [2:0] fl; int lat; bit ok, saw;
        exc_flag = 3'b000;
        dp_en = 1;
        dp_dly = 10;
        issue(0, 32'h3F800000, 32'h40000000, 1'b0, ok);
        tick; tick; tick;
        rst = 1;
        tick;
        rst = 0;
        saw = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (rsp_valid !== 1'b0) saw = 1;
        end
        vectors++;
        if (saw) begin miscompares++; $display("FAIL reset_run_rsp got rsp_valid=1 want 0"); end
        dp_dly = 4;
        exc_flag = 3'b001;
        issue(1, 32'h0, 32'h0, 1'b0, ok);
        get_rsp(20, r, id, fl, er, lat, ok);
        vectors++;
        if (!ok || id !== 1'b1 || r !== 32'h7FC00000 || lat !== 2) begin
            miscompares++;
            $display("FAIL post_reset_op got ok=%0d id=%b %h lat=%0d want id=1 7fc00000 lat=2", ok, id, r, lat);
        end
        ack;
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_arbitration();
        test_resolve();
        test_timeout();
        test_reset_in_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got hang want completion");
        $fatal(1, "bench did not complete");
    end

endmodule
